// File: rtl/vga_pkg.sv
// Shared VGA/background constants and the screen controller's state and direction types.
// Contents: VER_PIXELS, IMAGE_WIDTH, IMAGE_HEIGHT, SCREEN_WORDS, the state and direction
// enums, and helpers for the per-screen base address and the y correction applied on a swap.
package vga_pkg;

    localparam int unsigned VER_PIXELS   = 600;
    localparam int unsigned IMAGE_WIDTH  = 64;
    localparam int unsigned IMAGE_HEIGHT = 48;
    localparam int unsigned SCREEN_WORDS = IMAGE_WIDTH * IMAGE_HEIGHT;

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned Y_W    = 12;

    // Vertical distance between stacked screens, as a signed player coordinate
    localparam logic signed [Y_W-1:0] Y_STEP = Y_W'(VER_PIXELS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        SWAP     = 2'd2,
        COOLDOWN = 2'd3
    } screen_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } screen_dir_t;

    // First background word of a screen; unsigned, wraps to 15 bits (max 7*3072 fits)
    function automatic logic [ADDR_W-1:0] screen_base(input logic [IDX_W-1:0] idx);
        return ADDR_W'(idx) * ADDR_W'(SCREEN_WORDS);
    endfunction

    // Offset the player logic adds to its y when the screen changes
    function automatic logic signed [Y_W-1:0] dir_offset(input screen_dir_t dir);
        logic signed [Y_W-1:0] off;
        off = '0;
        case (dir)
            DIR_UP:   off = Y_STEP;
            DIR_DOWN: off = -Y_STEP;
            default:  off = '0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/screen_ctrl.sv
// Vertical screen-stack controller: tracks which background screen is shown and moves
// up/down when the player leaves the top/bottom edge, or jumps on an explicit load.
// Changes are committed only at the start of vertical blanking so the background never
// switches mid-frame, followed by a cooldown of a few frames that ignores further exits.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   vblnk              - vertical blanking flag
//   player_y/_valid    - signed player top edge and its one-cycle qualifier
//   load_req/_screen   - direct jump request and target; load_ack pulses one cycle later
//   screen_idx         - current screen, bg_base_addr its first background word
//   swap, y_correct    - one-cycle change pulse and the y offset valid with it
//   busy               - FSM not in IDLE
module screen_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned NUM_SCREENS     = 8,
    parameter int unsigned COOLDOWN_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vblnk,
    input  logic signed [11:0]    player_y,
    input  logic                  player_y_valid,
    input  logic                  load_req,
    input  logic [2:0]            load_screen,
    output logic                  load_ack,
    output logic [2:0]            screen_idx,
    output logic [14:0]           bg_base_addr,
    output logic                  swap,
    output logic signed [11:0]    y_correct,
    output logic                  busy
);

    localparam int unsigned CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN_FRAMES - 1);

    screen_state_t     state;
    screen_dir_t       dir;
    logic [IDX_W-1:0]  target;
    logic [CNT_W-1:0]  frame_cnt;
    logic              vblnk_q;

    logic vblnk_rise;
    logic exit_up;
    logic exit_down;
    logic load_take;
    logic load_valid;

    // Event decode shared by all states
    always_comb begin
        vblnk_rise = vblnk && !vblnk_q;
        exit_up    = player_y_valid && player_y[11]
                     && (32'(screen_idx) < NUM_SCREENS - 1);
        exit_down  = player_y_valid && !player_y[11] && (player_y >= Y_STEP)
                     && (screen_idx != '0);
        // Loads are held off during the single swap cycle
        load_take  = load_req && (state != SWAP);
        load_valid = 32'(load_screen) < NUM_SCREENS;
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dir          <= DIR_NONE;
            target       <= '0;
            frame_cnt    <= '0;
            vblnk_q      <= 1'b0;
            screen_idx   <= '0;
            bg_base_addr <= '0;
            swap         <= 1'b0;
            load_ack     <= 1'b0;
            y_correct    <= '0;
            busy         <= 1'b0;
        end else begin
            vblnk_q   <= vblnk;
            load_ack  <= 1'b0;
            swap      <= 1'b0;
            y_correct <= '0;

            if (load_take && load_valid) begin
                // A valid load overrides any exit or pending change
                load_ack  <= 1'b1;
                target    <= load_screen;
                dir       <= DIR_NONE;
                frame_cnt <= '0;
                state     <= ARMED;
                busy      <= 1'b1;
            end else begin
                // An out-of-range target is acknowledged and otherwise dropped
                if (load_take) begin
                    load_ack <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (exit_up) begin
                            target <= screen_idx + 3'd1;
                            dir    <= DIR_UP;
                            state  <= ARMED;
                            busy   <= 1'b1;
                        end else if (exit_down) begin
                            target <= screen_idx - 3'd1;
                            dir    <= DIR_DOWN;
                            state  <= ARMED;
                            busy   <= 1'b1;
                        end
                    end

                    ARMED: begin
                        // Commit at the start of blanking; outputs land in the SWAP cycle
                        if (vblnk_rise) begin
                            screen_idx   <= target;
                            bg_base_addr <= screen_base(target);
                            swap         <= 1'b1;
                            y_correct    <= dir_offset(dir);
                            state        <= SWAP;
                        end
                    end

                    SWAP: begin
                        frame_cnt <= '0;
                        state     <= COOLDOWN;
                    end

                    COOLDOWN: begin
                        if (vblnk_rise) begin
                            if (frame_cnt == CNT_LAST) begin
                                frame_cnt <= '0;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end else begin
                                frame_cnt <= frame_cnt + CNT_W'(1);
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_screen_ctrl.sv
// Directed bench for screen_ctrl. Expected swaps are queued when the stimulus that causes
// them is driven and checked by a monitor when swap pulses. A second instance with
// NUM_SCREENS=6 exercises out-of-range load targets, which a 3-bit port cannot express
// with 8 screens.
module tb_screen_ctrl;

    typedef struct {
        int idx;
        int base;
        int yc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               vblnk;
    logic signed [11:0] player_y;
    logic               player_y_valid;
    logic               load_req;
    logic [2:0]         load_screen;
    logic               load_ack;
    logic [2:0]         screen_idx;
    logic [14:0]        bg_base_addr;
    logic               swap;
    logic signed [11:0] y_correct;
    logic               busy;

    logic               load_req2;
    logic [2:0]         load_screen2;
    logic               load_ack2;
    logic [2:0]         screen_idx2;
    logic [14:0]        bg_base_addr2;
    logic               swap2;
    logic signed [11:0] y_correct2;
    logic               busy2;
    logic signed [11:0] player_y2 = 12'sd100;
    logic               player_y_valid2 = 1'b0;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    screen_ctrl #(.NUM_SCREENS(8), .COOLDOWN_FRAMES(4)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk),
        .player_y(player_y), .player_y_valid(player_y_valid),
        .load_req(load_req), .load_screen(load_screen), .load_ack(load_ack),
        .screen_idx(screen_idx), .bg_base_addr(bg_base_addr), .swap(swap),
        .y_correct(y_correct), .busy(busy)
    );

    screen_ctrl #(.NUM_SCREENS(6), .COOLDOWN_FRAMES(4)) dut6 (
        .clk(clk), .rst(rst), .vblnk(vblnk),
        .player_y(player_y2), .player_y_valid(player_y_valid2),
        .load_req(load_req2), .load_screen(load_screen2), .load_ack(load_ack2),
        .screen_idx(screen_idx2), .bg_base_addr(bg_base_addr2), .swap(swap2),
        .y_correct(y_correct2), .busy(busy2)
    );

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (swap) begin
            if (exp_q.size() == 0) begin
                check("unexpected_swap", int'(screen_idx), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("swap_idx", int'(screen_idx), e.idx);
                check("swap_base", int'(bg_base_addr), e.base);
                check("swap_ycorr", int'(y_correct), e.yc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_swap(input int idx, input int yc);
        exp_t e;
        e.idx  = idx;
        e.base = idx * 3072;
        e.yc   = yc;
        exp_q.push_back(e);
    endtask

    task automatic player(input int y);
        player_y       = 12'(y);
        player_y_valid = 1'b1;
        tick();
        player_y_valid = 1'b0;
    endtask

    task automatic load(input int s, input string tag);
        load_req    = 1'b1;
        load_screen = 3'(s);
        tick();
        load_req    = 1'b0;
        check(tag, int'(load_ack), 1);
    endtask

    task automatic load6(input int s, input string tag);
        load_req2    = 1'b1;
        load_screen2 = 3'(s);
        tick();
        load_req2    = 1'b0;
        check(tag, int'(load_ack2), 1);
    endtask

    task automatic pulse_vblank();
        vblnk = 1'b1;
        tick();
        tick();
        vblnk = 1'b0;
        tick();
    endtask

    task automatic cool();
        for (int i = 0; i < 4; i++) pulse_vblank();
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0; player_y = '0; player_y_valid = 1'b0;
        load_req = 1'b0; load_screen = '0; load_req2 = 1'b0; load_screen2 = '0;
        tick(); tick();
        check("rst_idx", int'(screen_idx), 0);
        check("rst_base", int'(bg_base_addr), 0);
        check("rst_swap", int'(swap), 0);
        check("rst_ack", int'(load_ack), 0);
        check("rst_ycorr", int'(y_correct), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // Exit past the top of screen 0, with latency checked against the vblnk edge
        player(-5);
        check("armed_busy", int'(busy), 1);
        expect_swap(1, 600);
        tick();
        check("armed_wait_noswap", int'(swap), 0);
        vblnk = 1'b1;
        tick();
        check("latency_swap", int'(swap), 1);
        tick();
        check("swap_one_cycle", int'(swap), 0);
        check("ycorr_cleared", int'(y_correct), 0);
        check("base_held", int'(bg_base_addr), 3072);
        vblnk = 1'b0;
        tick();

        // Exits during cooldown are ignored until the fourth blanking edge
        for (int i = 0; i < 3; i++) begin
            player(-5);
            pulse_vblank();
            check("cooldown_busy", int'(busy), 1);
            check("cooldown_idx", int'(screen_idx), 1);
        end
        player(-5);
        pulse_vblank();
        check("cooldown_done", int'(busy), 0);
        check("cooldown_idx_final", int'(screen_idx), 1);
        player(-5);
        check("post_cooldown_armed", int'(busy), 1);
        expect_swap(2, 600);
        pulse_vblank();
        cool();

        // Exit past the bottom
        player(650);
        check("down_armed", int'(busy), 1);
        expect_swap(1, -600);
        pulse_vblank();
        cool();

        // Load overrides a pending upward move
        player(-5);
        load(5, "load_ack_armed");
        tick();
        check("load_ack_single", int'(load_ack), 0);
        expect_swap(5, 0);
        pulse_vblank();
        check("load_idx", int'(screen_idx), 5);
        cool();

        // Bottom exit on screen 0 is ignored
        load(0, "load0_ack");
        expect_swap(0, 0);
        pulse_vblank();
        cool();
        player(650);
        check("bottom_ignored_busy", int'(busy), 0);
        pulse_vblank();
        check("bottom_ignored_idx", int'(screen_idx), 0);

        // Highest screen, then top exit there is ignored
        load(7, "load7_ack");
        expect_swap(7, 0);
        pulse_vblank();
        check("load7_base", int'(bg_base_addr), 21504);
        cool();
        player(-5);
        check("top_ignored_busy", int'(busy), 0);

        // Load raised during SWAP waits one cycle
        load(3, "load3_ack");
        expect_swap(3, 0);
        vblnk = 1'b1;
        tick();
        load_req = 1'b1;
        load_screen = 3'd6;
        tick();
        check("swap_holdoff_ack", int'(load_ack), 0);
        tick();
        check("holdoff_late_ack", int'(load_ack), 1);
        load_req = 1'b0;
        vblnk = 1'b0;
        expect_swap(6, 0);
        tick();
        pulse_vblank();
        cool();

        // Load wins over a simultaneous exit
        player_y = -12'sd5;
        player_y_valid = 1'b1;
        load_req = 1'b1;
        load_screen = 3'd2;
        tick();
        player_y_valid = 1'b0;
        load_req = 1'b0;
        check("race_ack", int'(load_ack), 1);
        expect_swap(2, 0);
        pulse_vblank();
        cool();

        // Reset while armed abandons the move
        player(-5);
        check("pre_rst_armed", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        pulse_vblank();
        check("rst_mid_idx", int'(screen_idx), 0);

        // Out-of-range targets on the six-screen instance
        load6(7, "bad_load_ack_idle");
        check("bad_load_idle_busy", int'(busy2), 0);
        load6(4, "load6_ack");
        check("load6_armed", int'(busy2), 1);
        load6(6, "bad_load_ack_armed");
        check("bad_load_armed_busy", int'(busy2), 1);
        pulse_vblank();
        check("load6_idx", int'(screen_idx2), 4);
        check("load6_base", int'(bg_base_addr2), 12288);

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
